// File: rtl/mul_seq32_pkg.sv
// Shared constants for the sequential 32x32 multiplier: widths, FSM encoding, iteration bound.
package mul_seq32_pkg;

   localparam int unsigned WIDTH  = 32;
   localparam int unsigned PROD_W = 2 * WIDTH;
   localparam int unsigned ADD_W  = WIDTH + 1;
   localparam int unsigned CNT_W  = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] ITER_LAST = 5'd31;

endpackage

// File: rtl/mul_add33.sv
// 33-bit carry look-ahead adder slice (4-bit lookahead groups) shared by every multiply iteration.
// With MUL_SIGNED_EN the b operand is a full 33 bits; otherwise it is 32 bits zero-extended.
module mul_add33
   import mul_seq32_pkg::*;
(
   input  logic [ADD_W-1:0] a,
`ifdef MUL_SIGNED_EN
   input  logic [ADD_W-1:0] b,
`else
   input  logic [WIDTH-1:0] b,
`endif
   input  logic             ci,
   output logic [ADD_W-1:0] s
);

   logic [ADD_W-1:0] b_ext;
   logic [ADD_W-1:0] p;
   logic [WIDTH-1:0] g;
   logic [ADD_W-1:0] c;

`ifdef MUL_SIGNED_EN
   assign b_ext = b;
`else
   assign b_ext = {1'b0, b};
`endif

   // Carries inside each nibble are computed directly from g/p; groups chain on their carry-in.
   always_comb begin
      p = a ^ b_ext;
      g = a[WIDTH-1:0] & b_ext[WIDTH-1:0];
      c = '0;
      c[0] = ci;
      for (int k = 0; k < 8; k++) begin
         c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
         c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
         c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
         c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      end
      s = p ^ c;
   end

endmodule

// File: rtl/mul_seq32.sv
// Multi-cycle 32x32->64 shift-add multiplier with start/busy/done handshake around one 33-bit adder.
// Define MUL_SIGNED_EN to add the op_signed port and radix-2 Booth signed mode.
module mul_seq32
   import mul_seq32_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [WIDTH-1:0]  multiplicand,
   input  logic [WIDTH-1:0]  multiplier,
`ifdef MUL_SIGNED_EN
   input  logic              op_signed,
`endif
   output logic              busy,
   output logic              done,
   output logic [PROD_W-1:0] result
);

   state_t             state, state_nxt;
   logic               accept;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   p_lo;
   logic [ADD_W-1:0]   acc;
   logic [ADD_W-1:0]   sum;
   logic               add_ci;
   logic               shift_msb;
   logic [ADD_W-1:0]   acc_nxt;
   logic [WIDTH-1:0]   plo_nxt;
`ifdef MUL_SIGNED_EN
   logic               sgn;
   logic               q_m1;
   logic [ADD_W-1:0]   mcand_x;
   logic [ADD_W-1:0]   add_b;
`else
   logic [WIDTH-1:0]   add_b;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // Next state; start is only honoured in IDLE or DONE.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (cnt == ITER_LAST) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = ST_EXEC;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Adder operand selection and the one-bit right shift of {acc, p_lo}.
   always_comb begin
      add_b     = '0;
      add_ci    = 1'b0;
      shift_msb = 1'b0;
`ifdef MUL_SIGNED_EN
      mcand_x = sgn ? {mcand[WIDTH-1], mcand} : {1'b0, mcand};
      if (sgn) begin
         case ({p_lo[0], q_m1})
            2'b01:   add_b = mcand_x;
            2'b10: begin
               add_b  = ~mcand_x;
               add_ci = 1'b1;
            end
            default: add_b = '0;
         endcase
         shift_msb = sum[ADD_W-1];
      end else if (p_lo[0]) begin
         add_b = mcand_x;
      end
`else
      if (p_lo[0]) add_b = mcand;
`endif
      acc_nxt = {shift_msb, sum[ADD_W-1:1]};
      plo_nxt = {sum[0], p_lo[WIDTH-1:1]};
   end

   mul_add33 u_add (
      .a  (acc),
      .b  (add_b),
      .ci (add_ci),
      .s  (sum)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt    <= '0;
         mcand  <= '0;
         p_lo   <= '0;
         acc    <= '0;
         result <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
`ifdef MUL_SIGNED_EN
         sgn    <= 1'b0;
         q_m1   <= 1'b0;
`endif
      end else begin
         busy <= (state_nxt == ST_EXEC);
         done <= (state_nxt == ST_DONE);
         if (accept) begin
            mcand <= multiplicand;
            p_lo  <= multiplier;
            acc   <= '0;
            cnt   <= '0;
`ifdef MUL_SIGNED_EN
            sgn   <= op_signed;
            q_m1  <= 1'b0;
`endif
         end else if (state == ST_EXEC) begin
            acc  <= acc_nxt;
            p_lo <= plo_nxt;
            cnt  <= cnt + CNT_W'(1);
`ifdef MUL_SIGNED_EN
            q_m1 <= p_lo[0];
`endif
            if (cnt == ITER_LAST) result <= {acc_nxt[WIDTH-1:0], plo_nxt};
         end
      end
   end

endmodule
